// File: rtl/ram_arbiter_pkg.sv
// Shared widths, FSM state type and request payload for the RAM arbiter.
package ram_arbiter_pkg;

  localparam int unsigned FULLW = 32;
  localparam int unsigned BYTEW = 8;
  localparam int unsigned WORD  = FULLW / BYTEW;
  localparam int unsigned LANEW = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RMW  = 1'b1
  } state_e;

  typedef struct packed {
    logic             we;
    logic             byte_acc;
    logic [FULLW-1:0] addr;
    logic [FULLW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/ram_arbiter_byte_lane.sv
// Byte-lane helper: extracts a lane for byte reads and merges a byte into a word for RMW.
module ram_arbiter_byte_lane
  import ram_arbiter_pkg::*;
(
  input  logic [FULLW-1:0] word,
  input  logic [LANEW-1:0] lane,
  input  logic [BYTEW-1:0] new_byte,
  output logic [FULLW-1:0] extract,
  output logic [FULLW-1:0] merged
);

  // Little-endian lanes: lane i occupies bits [8i+7:8i].
  always_comb begin
    extract = '0;
    merged  = word;
    for (int i = 0; i < int'(WORD); i++) begin
      if (lane == LANEW'(i)) begin
        extract = FULLW'(word[i*BYTEW +: BYTEW]);
        merged[i*BYTEW +: BYTEW] = new_byte;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a 1W/1R synchronous RAM, adding byte reads
// (lane extract) and byte writes (one-cycle read-modify-write).
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_req,
  input  logic             r0_we,
  input  logic             r0_byte,
  input  logic [FULLW-1:0] r0_addr,
  input  logic [FULLW-1:0] r0_wdata,
  output logic             r0_gnt,
  output logic             r0_err,
  output logic             r0_rvalid,
  output logic [FULLW-1:0] r0_rdata,
  input  logic             r1_req,
  input  logic             r1_we,
  input  logic             r1_byte,
  input  logic [FULLW-1:0] r1_addr,
  input  logic [FULLW-1:0] r1_wdata,
  output logic             r1_gnt,
  output logic             r1_err,
  output logic             r1_rvalid,
  output logic [FULLW-1:0] r1_rdata,
  output logic [FULLW-1:0] ram_wa,
  output logic [FULLW-1:0] ram_wd,
  output logic             ram_we,
  output logic [FULLW-1:0] ram_ra,
  input  logic [FULLW-1:0] ram_out
);

  state_e           state;
  logic             last_winner;
  logic             rd_pending;
  logic             rd_owner;
  logic [LANEW-1:0] rd_lane;
  logic             rd_byte;
  logic             rd_err;
  logic [FULLW-1:0] rmw_addr;
  logic [BYTEW-1:0] rmw_byte;

  req_t             sel;
  logic             pick1;
  logic             grant;
  logic             oor;
  logic [LANEW-1:0] lane;
  logic [FULLW-1:0] lane_ext;
  logic [FULLW-1:0] lane_merged;
  logic [FULLW-1:0] rd_word;

  // Winner select: r1 wins when alone, or on a tie when r0 won last (round-robin only).
  always_comb begin
    pick1 = r1_req && (!r0_req || (!FIXED_PRIO && !last_winner));
    sel   = pick1 ? '{we: r1_we, byte_acc: r1_byte, addr: r1_addr, wdata: r1_wdata}
                  : '{we: r0_we, byte_acc: r0_byte, addr: r0_addr, wdata: r0_wdata};
    grant = rst_n && (state == ST_IDLE) && (r0_req || r1_req);
    oor   = (sel.addr >> (ADDR_WIDTH + 32'd2)) != '0;
    lane  = (state == ST_RMW) ? rmw_addr[LANEW-1:0] : rd_lane;
  end

  ram_arbiter_byte_lane u_byte_lane (
    .word     (ram_out),
    .lane     (lane),
    .new_byte (rmw_byte),
    .extract  (lane_ext),
    .merged   (lane_merged)
  );

  // Grant/err pulses and RAM port drive; the RMW merge write owns the RAM in its cycle.
  always_comb begin
    r0_gnt = grant && !pick1;
    r1_gnt = grant && pick1;
    r0_err = r0_gnt && oor;
    r1_err = r1_gnt && oor;
    ram_ra = sel.addr;
    ram_wa = sel.addr;
    ram_wd = sel.wdata;
    ram_we = grant && sel.we && !sel.byte_acc && !oor;
    if (rst_n && (state == ST_RMW)) begin
      ram_we = 1'b1;
      ram_wa = rmw_addr;
      ram_wd = lane_merged;
    end
  end

  // Read return lands on the cycle after the grant, steered to the owner only.
  always_comb begin
    rd_word   = rd_err ? '0 : (rd_byte ? lane_ext : ram_out);
    r0_rvalid = rd_pending && !rd_owner;
    r1_rvalid = rd_pending && rd_owner;
    r0_rdata  = r0_rvalid ? rd_word : '0;
    r1_rdata  = r1_rvalid ? rd_word : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_winner <= 1'b1;
      rd_pending  <= 1'b0;
      rd_owner    <= 1'b0;
      rd_lane     <= '0;
      rd_byte     <= 1'b0;
      rd_err      <= 1'b0;
      rmw_addr    <= '0;
      rmw_byte    <= '0;
    end else begin
      rd_pending <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            last_winner <= pick1;
            if (!sel.we) begin
              rd_pending <= 1'b1;
              rd_owner   <= pick1;
              rd_lane    <= sel.addr[LANEW-1:0];
              rd_byte    <= sel.byte_acc;
              rd_err     <= oor;
            end else if (sel.byte_acc && !oor) begin
              rmw_addr <= sel.addr;
              rmw_byte <= sel.wdata[BYTEW-1:0];
              state    <= ST_RMW;
            end
          end
        end
        ST_RMW:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
